// File: rtl/l0_feed_seq_pkg.sv
// Shared types and constants for the l0 feed sequencer.
package l0_feed_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    FLUSH,
    FIN
  } state_t;

  localparam int ROW_DEFAULT   = 8;
  localparam int DEPTH_DEFAULT = 16;

  // Occupancy must be able to hold the value depth itself, hence the extra bit.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/l0_feed_seq_occ_counter.sv
// Occupancy counter for the l0 row FIFOs.
// count : vectors currently held in l0 (registered).
// space : free slots l0 will have next cycle once the read now in flight
//         from SRAM has landed; zero means no new read may be issued.
module occ_counter
  import l0_feed_seq_pkg::*;
#(
  parameter int depth = DEPTH_DEFAULT,
  parameter int occ_w = occ_width(DEPTH_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             inflight,
  output logic [occ_w-1:0] count,
  output logic [occ_w-1:0] space
);

  logic [occ_w-1:0] count_reg;
  logic [occ_w-1:0] count_next;
  logic [occ_w:0]   pending;

  // Saturating up/down step; write and read together cancel out.
  always_comb begin
    count_next = count_reg;
    if (inc && !dec && (count_reg < occ_w'(depth))) begin
      count_next = count_reg + 1'b1;
    end else if (dec && !inc && (count_reg != '0)) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Occupancy register, cleared by the active-low synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count   = count_reg;
  assign pending = {1'b0, count_next} + {{occ_w{1'b0}}, inflight};
  assign space   = (pending >= (occ_w+1)'(depth)) ? '0
                 : occ_w'((occ_w+1)'(depth) - pending);

endmodule

// File: rtl/l0_feed_seq.sv
// l0 feed sequencer: SRAM -> l0 row FIFOs -> PE array.
// Optional feature macro L0_FEED_OVERLAP_EN: when defined, l0 reads overlap
// the load phase and bursts longer than the FIFO depth are accepted.
// All outputs are registered; decisions for cycle k are taken in cycle k-1.
module l0_feed_seq
  import l0_feed_seq_pkg::*;
#(
  parameter int row     = ROW_DEFAULT,
  parameter int depth   = DEPTH_DEFAULT,
  parameter int addr_bw = 11,
  parameter int len_bw  = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] base_addr,
  input  logic [len_bw-1:0]  len,
  input  logic               drain_en,
  input  logic               l0_full,
  output logic               sram_cen,
  output logic [addr_bw-1:0] sram_addr,
  output logic               l0_wr,
  output logic               l0_rd,
  output logic               busy,
  output logic               done,
  output logic               err
);

`ifdef L0_FEED_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  localparam int occ_w   = occ_width(depth);
  localparam int flush_w = $clog2(row) + 1;
  localparam logic [flush_w-1:0] FLUSH_LAST = flush_w'(row - 2);
  // With a single row there is no skew to wait out.
  localparam state_t AFTER_RD = (row > 1) ? FLUSH : FIN;

  state_t             state_reg, state_next;
  logic [addr_bw-1:0] base_reg, base_next, base_eff;
  logic [len_bw-1:0]  len_reg, len_next, len_eff;
  logic [len_bw-1:0]  issue_cnt_reg, issue_cnt_next;
  logic [len_bw-1:0]  rd_cnt_reg, rd_cnt_next;
  logic [flush_w-1:0] flush_cnt_reg, flush_cnt_next;
  logic               sram_cen_reg, sram_cen_next;
  logic [addr_bw-1:0] sram_addr_reg, sram_addr_next;
  logic               l0_wr_reg, l0_wr_next;
  logic               l0_rd_reg, l0_rd_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;

  logic [occ_w-1:0]   occ_count;
  logic [occ_w-1:0]   occ_space;
  logic               occ_avail;
  logic               issue_ok;
  logic               rd_ok;

  occ_counter #(
    .depth (depth),
    .occ_w (occ_w)
  ) u_occ (
    .clk      (clk),
    .reset    (reset),
    .inc      (l0_wr_reg),
    .dec      (l0_rd_reg),
    .inflight (~sram_cen_reg),
    .count    (occ_count),
    .space    (occ_space)
  );

  // l0 will hold at least one vector next cycle.
  assign occ_avail = l0_wr_reg || (occ_count > occ_w'(1))
                  || ((occ_count == occ_w'(1)) && !l0_rd_reg);
  // While idle the burst parameters come straight from the inputs.
  assign base_eff  = (state_reg == IDLE) ? base_addr : base_reg;
  assign len_eff   = (state_reg == IDLE) ? len : len_reg;

  // Next-state plus next values of every registered output.
  always_comb begin
    state_next     = state_reg;
    base_next      = base_reg;
    len_next       = len_reg;
    issue_cnt_next = issue_cnt_reg;
    rd_cnt_next    = rd_cnt_reg;
    flush_cnt_next = '0;
    sram_cen_next  = 1'b1;
    sram_addr_next = sram_addr_reg;
    l0_wr_next     = ~sram_cen_reg;
    l0_rd_next     = 1'b0;
    err_next       = 1'b0;
    issue_ok       = 1'b0;
    rd_ok          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          base_next = base_addr;
          len_next  = len;
          if ((len == '0) || (!OVERLAP && (int'(len) > depth))) begin
            state_next = FIN;
            err_next   = 1'b1;
          end else begin
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        if (OVERLAP) begin
          if (rd_cnt_reg == len_reg) state_next = AFTER_RD;
        end else begin
          // All reads issued and nothing left in flight from SRAM.
          if ((issue_cnt_reg == len_reg) && sram_cen_reg) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (rd_cnt_reg == len_reg) state_next = AFTER_RD;
      end
      FLUSH: begin
        flush_cnt_next = flush_cnt_reg + 1'b1;
        if (flush_cnt_reg == FLUSH_LAST) state_next = FIN;
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    issue_ok = (state_next == LOAD) && (issue_cnt_reg < len_eff)
            && (occ_space != '0) && !l0_full;
    if (issue_ok) begin
      sram_cen_next  = 1'b0;
      sram_addr_next = base_eff + addr_bw'(issue_cnt_reg);
      issue_cnt_next = issue_cnt_reg + 1'b1;
    end

    rd_ok = ((state_next == DRAIN) || (OVERLAP && (state_next == LOAD)))
         && (rd_cnt_reg < len_eff) && occ_avail && drain_en;
    if (rd_ok) begin
      l0_rd_next  = 1'b1;
      rd_cnt_next = rd_cnt_reg + 1'b1;
    end

    busy_next = (state_next == LOAD) || (state_next == DRAIN) || (state_next == FLUSH);
    done_next = (state_next == FIN);
    if (state_next == FIN) begin
      issue_cnt_next = '0;
      rd_cnt_next    = '0;
    end
  end

  // State and output registers; reset also drops any read still in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      base_reg      <= '0;
      len_reg       <= '0;
      issue_cnt_reg <= '0;
      rd_cnt_reg    <= '0;
      flush_cnt_reg <= '0;
      sram_cen_reg  <= 1'b1;
      sram_addr_reg <= '0;
      l0_wr_reg     <= 1'b0;
      l0_rd_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      base_reg      <= base_next;
      len_reg       <= len_next;
      issue_cnt_reg <= issue_cnt_next;
      rd_cnt_reg    <= rd_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
      sram_cen_reg  <= sram_cen_next;
      sram_addr_reg <= sram_addr_next;
      l0_wr_reg     <= l0_wr_next;
      l0_rd_reg     <= l0_rd_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  assign sram_cen  = sram_cen_reg;
  assign sram_addr = sram_addr_reg;
  assign l0_wr     = l0_wr_reg;
  assign l0_rd     = l0_rd_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_l0_feed_seq.sv
// Directed testbench for l0_feed_seq (default build; extra section when
// L0_FEED_OVERLAP_EN is defined).
module tb_l0_feed_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] base_addr;
  logic [10:0] len;
  logic        drain_en;
  logic        l0_full;
  logic        sram_cen;
  logic [10:0] sram_addr;
  logic        l0_wr;
  logic        l0_rd;
  logic        busy;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;
  int wr_seen = 0;
  int rd_seen = 0;
  int cen_seen = 0;
  int max_occ = 0;

  always #5 clk = ~clk;

  l0_feed_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .drain_en  (drain_en),
    .l0_full   (l0_full),
    .sram_cen  (sram_cen),
    .sram_addr (sram_addr),
    .l0_wr     (l0_wr),
    .l0_rd     (l0_rd),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Strobe and occupancy tallies over the whole run.
  always @(posedge clk) begin
    if (l0_wr) wr_seen <= wr_seen + 1;
    if (l0_rd) rd_seen <= rd_seen + 1;
    if (!sram_cen) cen_seen <= cen_seen + 1;
    if (int'(dut.u_occ.count) > max_occ) max_occ <= int'(dut.u_occ.count);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cen"},  32'(sram_cen),  32'd1);
    check({tag, "_addr"}, 32'(sram_addr), 32'd0);
    check({tag, "_wr"},   32'(l0_wr),     32'd0);
    check({tag, "_rd"},   32'(l0_rd),     32'd0);
    check({tag, "_busy"}, 32'(busy),      32'd0);
    check({tag, "_done"}, 32'(done),      32'd0);
    check({tag, "_err"},  32'(err),       32'd0);
  endtask

  task automatic pulse_start(input logic [10:0] b, input logic [10:0] l);
    base_addr = b;
    len       = l;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles, input bit toggle);
    int n = 0;
    while (!done && n < max_cycles) begin
      if (toggle) drain_en = ~drain_en;
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int wr0, rd0, cen0;
    logic [16:0] exp_cen, exp_wr, exp_rd, exp_busy, exp_done;

    reset = 1'b0; start = 1'b0; base_addr = '0; len = '0;
    drain_en = 1'b0; l0_full = 1'b0;
    tick(); tick(); tick();
    check_reset_outputs("por");
    reset = 1'b1;
    tick();

    // Reset held low for 3 cycles in the middle of a LOAD.
    pulse_start(11'h020, 11'd8);
    check("midload_busy", 32'(busy), 32'd1);
    tick(); tick();
    check("midload_wr_active", 32'(l0_wr), 32'd1);
    reset = 1'b0;
    tick(); tick(); tick();
    check_reset_outputs("midrst");
    check("midrst_occ", 32'(dut.u_occ.count), 32'd0);
    reset = 1'b1;
    wr0 = wr_seen;
    tick(); tick(); tick(); tick(); tick();
    check("midrst_no_wr", 32'(wr_seen - wr0), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);

`ifndef L0_FEED_OVERLAP_EN
    // len=4 at 0x10: cycle-by-cycle profile for cycles t+1..t+17 (bit k-1 = cycle t+k).
    exp_cen  = 17'b1_1111_1111_1111_0000;
    exp_wr   = 17'b0_0000_0000_0001_1110;
    exp_rd   = 17'b0_0000_0001_1110_0000;
    exp_busy = 17'b0_1111_1111_1111_1111;
    exp_done = 17'b1_0000_0000_0000_0000;
    drain_en = 1'b1;
    pulse_start(11'h010, 11'd4);
    for (int k = 1; k <= 17; k++) begin
      check($sformatf("len4_cen_t%0d", k),  32'(sram_cen), 32'(exp_cen[k-1]));
      check($sformatf("len4_wr_t%0d", k),   32'(l0_wr),    32'(exp_wr[k-1]));
      check($sformatf("len4_rd_t%0d", k),   32'(l0_rd),    32'(exp_rd[k-1]));
      check($sformatf("len4_busy_t%0d", k), 32'(busy),     32'(exp_busy[k-1]));
      check($sformatf("len4_done_t%0d", k), 32'(done),     32'(exp_done[k-1]));
      if (k <= 4) check($sformatf("len4_addr_t%0d", k), 32'(sram_addr), 32'h10 + 32'(k - 1));
      if (k == 17) check("len4_err", 32'(err), 32'd0);
      tick();
    end
    check("len4_done_one_cycle", 32'(done), 32'd0);
`endif

    // len=16 with the array stalled: buffer fills exactly, then drains.
    drain_en = 1'b0;
    wr0 = wr_seen; rd0 = rd_seen;
    pulse_start(11'h100, 11'd16);
    for (int k = 1; k < 30; k++) tick();
    check("full16_writes", 32'(wr_seen - wr0), 32'd16);
    check("full16_occ", 32'(dut.u_occ.count), 32'd16);
    check("full16_no_rd", 32'(rd_seen - rd0), 32'd0);
    check("full16_busy", 32'(busy), 32'd1);
    drain_en = 1'b1;
    wait_done("full16", 80, 1'b0);
    check("full16_reads", 32'(rd_seen - rd0), 32'd16);
    check("full16_busy_low", 32'(busy), 32'd0);
    tick();

    // Zero-length burst is rejected without touching SRAM.
    cen0 = cen_seen;
    pulse_start(11'h040, 11'd0);
    check("len0_done", 32'(done), 32'd1);
    check("len0_err", 32'(err), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    tick();
    check("len0_done_clear", 32'(done), 32'd0);
    check("len0_no_sram", 32'(cen_seen - cen0), 32'd0);

`ifndef L0_FEED_OVERLAP_EN
    // One more than the FIFO depth is rejected when overlap is off.
    cen0 = cen_seen;
    pulse_start(11'h040, 11'd17);
    check("len17_done", 32'(done), 32'd1);
    check("len17_err", 32'(err), 32'd1);
    check("len17_busy", 32'(busy), 32'd0);
    tick();
    check("len17_no_sram", 32'(cen_seen - cen0), 32'd0);
`endif

    // Address wrap at the top of the SRAM.
    drain_en = 1'b1;
    pulse_start(11'h7FE, 11'd4);
    check("wrap_addr0", 32'(sram_addr), 32'h7FE);
    tick();
    check("wrap_addr1", 32'(sram_addr), 32'h7FF);
    tick();
    check("wrap_addr2", 32'(sram_addr), 32'h000);
    tick();
    check("wrap_addr3", 32'(sram_addr), 32'h001);
    wait_done("wrap", 60, 1'b0);
    tick();

`ifdef L0_FEED_OVERLAP_EN
    // Long burst streaming through the buffer with a half-rate consumer.
    wr0 = wr_seen; rd0 = rd_seen;
    drain_en = 1'b1;
    pulse_start(11'h200, 11'd40);
    wait_done("ovl40", 400, 1'b1);
    check("ovl40_writes", 32'(wr_seen - wr0), 32'd40);
    check("ovl40_reads", 32'(rd_seen - rd0), 32'd40);
    tick();
`endif

    check("occ_never_over_depth", 32'(max_occ > 16), 32'd0);
    check("occ_final_empty", 32'(dut.u_occ.count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/l0_feed_seq.md
# l0_feed_seq

Sequencer that moves a burst of activation vectors from the activation SRAM into the `l0` row-FIFO buffer and drains them into the PE array. It issues SRAM reads, generates the `l0` write and read strobes, and tracks buffer occupancy so the 1-cycle SRAM read latency can never overflow a FIFO. It also waits out the `row-1` cycle read skew of `l0` before reporting completion. It sits between the core controller (start/done) and the `l0` plus SRAM macro.

## Interface
- `row`, 8, number of `l0` rows (FIFO lanes); skew length is `row-1`
- `depth`, 16, per-row FIFO depth inside `l0`
- `addr_bw`, 11, SRAM address width
- `len_bw`, 11, burst length width
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle pulse; sampled only in IDLE
- `base_addr`  in  addr_bw  first SRAM address of burst, sampled with `start`
- `len`  in  len_bw  number of vectors in burst, sampled with `start`
- `drain_en`  in  1  downstream array can accept a vector this cycle
- `l0_full`  in  1  `o_full` from `l0`; safety stall only
- `sram_cen`  out  1  SRAM chip enable, active-low (read)
- `sram_addr`  out  addr_bw  SRAM read address
- `l0_wr`  out  1  `l0` write strobe
- `l0_rd`  out  1  `l0` read strobe (row 0; `l0` skews the rest)
- `busy`  out  1  high from the cycle after accepted `start` until `done`
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  valid with `done`; burst rejected

## Operation
- States: IDLE, LOAD, DRAIN, FLUSH, FIN.
- IDLE: on `start`, latch `base_addr` and `len`.
  - If `len==0`, or `len>depth` with overlap off, go to FIN with `err=1`.
  - Otherwise go to LOAD.
- LOAD: issue a read (`sram_cen=0`, `sram_addr=base+issue_cnt`) when `occ + inflight < depth` and `!l0_full`.
  - `inflight` is the read issued the previous cycle.
  - `l0_wr` is asserted exactly one cycle after each issued read.
  - After `len` reads are issued and the last write lands, go to DRAIN.
- DRAIN: assert `l0_rd` when `occ>0` and `drain_en`.
  - When `rd_cnt` reaches `len`, go to FLUSH.
- FLUSH: count `row-1` cycles so the last vector leaves row `row-1`, then go to FIN.
- FIN: `done=1` for one cycle, then go to IDLE.
- Occupancy counter:
  - `occ` is `$clog2(depth)+1` bits.
  - +1 on `l0_wr`, -1 on `l0_rd`; a simultaneous write and read leaves it unchanged.
  - `occ` never exceeds `depth` and never wraps below 0.
- `issue_cnt` and `rd_cnt` are `len_bw` bits.
  - Address arithmetic is modulo `2^addr_bw`; wrap at the top of SRAM is legal.
- `start` outside IDLE is ignored.
- `reset` low at any time:
  - All state goes to IDLE and counters clear.
  - Any SRAM data still in flight is dropped; no `l0_wr` is issued for it.

## Timing
- Reset values: `sram_cen=1`, `sram_addr=0`, `l0_wr=0`, `l0_rd=0`, `busy=0`, `done=0`, `err=0`.
- `start` at cycle t:
  - `busy=1` and first `sram_cen=0` at t+1.
  - First `l0_wr` at t+2.
- Throughput: one read per cycle while the occupancy rule permits.
- Rejected burst: `done=1`, `err=1` at t+1; `busy` stays 0.
- Last `l0_rd` at cycle r:
  - FLUSH occupies r+1..r+row-1.
  - `done` at r+row; `busy` falls with `done`.
- All outputs are registered.

## Configuration
- `L0_FEED_OVERLAP_EN` defined:
  - DRAIN rules also apply in LOAD, so reads from `l0` start as soon as `occ>0`.
  - LOAD moves directly to FLUSH once `rd_cnt==len`.
  - `len` up to `2^len_bw-1` is legal.
- Not defined:
  - Strict LOAD-then-DRAIN; no `l0_rd` while in LOAD.
  - `len>depth` is rejected with `err`.

## Structure
- Shared package holds:
  - the state enum (IDLE, LOAD, DRAIN, FLUSH, FIN)
  - default `row`/`depth` constants
  - the occupancy width function
- One sub-module, `occ_counter`: up/down counter with `inc`, `dec`, `count`, plus `space` = `depth - count - inflight`.

## Test plan
- Reset low for 3 cycles mid-LOAD with `len=8` -> next cycle all outputs at reset values, `occ=0`; no further `l0_wr`.
- `len=4`, `base_addr=0x10`, `drain_en=1`, overlap off:
  - `sram_addr` 0x10..0x13 at t+1..t+4.
  - `l0_wr` at t+2..t+5, then 4 `l0_rd`.
  - `done` exactly `row` cycles after the last `l0_rd`, `err=0`.
- `len=16`, `drain_en=0` for 30 cycles, overlap off -> exactly 16 writes, `occ` holds at 16; after `drain_en=1`, 16 reads then `done`.
- `len=0` -> `done=1`, `err=1` at t+1; no SRAM access. With overlap off, `len=17` behaves the same.
- Overlap on, `len=40`, `drain_en` toggling 1/0 each cycle -> `occ` never exceeds 16, 40 writes, 40 reads, `done` with `err=0`.
- `base_addr=0x7FE`, `len=4` -> `sram_addr` sequence 0x7FE, 0x7FF, 0x000, 0x001.
